mmio_bridge: RTL and testbench

Data-memory bridge that sits directly downstream of the processor's dmem port, between the core and the data RAM instantiated in the wrapper. It routes normal loads and stores to RAM unchanged. It decodes a small memory-mapped I/O window that feeds a peripheral output stream (hologram pixel/LED driver) through a word FIFO with a valid/ready handshake. It also provides status, drop-count and control registers that software reads and writes with plain lw/sw.

---
 rtl/mmio_pkg.sv | 14 +
 rtl/sync_fifo.sv | 65 ++++++
 rtl/mmio_bridge.sv | 91 +++++++++
 tb/tb_mmio_bridge.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Register offsets and bit positions shared by the MMIO bridge and its users.
package mmio_pkg;
  localparam logic [31:0] OFF_DATA   = 32'd0;
  localparam logic [31:0] OFF_STATUS = 32'd1;
  localparam logic [31:0] OFF_DROPS  = 32'd2;
  localparam logic [31:0] OFF_CTRL   = 32'd3;

  localparam int STAT_EMPTY   = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_CNT_LSB = 4;

  localparam int CTRL_FLUSH     = 0;
  localparam int CTRL_CLR_DROPS = 1;
endpackage

// File: rtl/sync_fifo.sv
// Word FIFO with registered pointers and a head output that is zero while empty.
// Push visible one cycle later; a push into a full FIFO lands only if a pop happens in the same cycle; flush beats push/pop.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_pop, do_push;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = empty ? '0 : mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end
endmodule

// File: rtl/mmio_bridge.sv
// Routes dmem traffic to RAM or an MMIO window feeding a valid/ready word stream; loads return in one cycle.
// Backpressure: pushes into a full FIFO without a same-cycle pop are dropped and counted in DROPS.
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE  = 32'h0000_1000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] proc_addr,
  input  logic [31:0] proc_data,
  input  logic        proc_wren,
  input  logic        proc_hold,
  output logic [31:0] proc_q,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_data,
  output logic        ram_wren,
  input  logic [31:0] ram_q,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          is_mmio, store_ev, data_wr, ctrl_wr, flush, clr_drops, pop, drop;
  logic [31:0]   off, status;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [31:0]   drops_q, drops_d, rd_mmio_q, rd_mmio_d;
  logic          rd_sel_q, rd_sel_d;

  assign is_mmio   = (proc_addr >= MMIO_BASE);
  assign off       = proc_addr - MMIO_BASE;
  assign ram_addr  = proc_addr;
  assign ram_data  = proc_data;
  assign ram_wren  = proc_wren & ~is_mmio;
  // A held store is the same instruction repeating, so it must not act twice.
  assign store_ev  = proc_wren & ~proc_hold & is_mmio;
  assign data_wr   = store_ev & (off == OFF_DATA);
  assign ctrl_wr   = store_ev & (off == OFF_CTRL);
  assign flush     = ctrl_wr & proc_data[CTRL_FLUSH];
  assign clr_drops = ctrl_wr & proc_data[CTRL_CLR_DROPS];
  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;
  assign drop      = data_wr & ~flush & fifo_full & ~pop;
  assign proc_q    = rd_sel_q ? rd_mmio_q : ram_q;

  sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (data_wr),
    .push_dat (proc_data),
    .pop      (pop),
    .flush    (flush),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .head     (out_data)
  );

  always_comb begin
    status                        = '0;
    status[STAT_EMPTY]            = fifo_empty;
    status[STAT_FULL]             = fifo_full;
    status[STAT_CNT_LSB +: 4]     = 4'(fifo_count);

    drops_d = drops_q;
    if (clr_drops)                  drops_d = '0;
    else if (drop && drops_q != '1) drops_d = drops_q + 32'd1;

    rd_sel_d  = is_mmio;
    rd_mmio_d = '0;
    if (is_mmio) begin
      if (off == OFF_STATUS)     rd_mmio_d = status;
      else if (off == OFF_DROPS) rd_mmio_d = drops_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      drops_q   <= '0;
      rd_sel_q  <= 1'b0;
      rd_mmio_q <= '0;
    end else begin
      drops_q   <= drops_d;
      rd_sel_q  <= rd_sel_d;
      rd_mmio_q <= rd_mmio_d;
    end
  end
endmodule

// File: tb/tb_mmio_bridge.sv
// Bench for mmio_bridge: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_mmio_bridge;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] proc_addr = '0, proc_data = '0;
  logic        proc_wren = 1'b0, proc_hold = 1'b0, out_ready = 1'b0;
  logic [31:0] proc_q, ram_addr, ram_data, ram_q, out_data;
  logic        ram_wren, out_valid;

  always #5 clock = ~clock;

  mmio_bridge #(.FIFO_DEPTH(DEPTH), .MMIO_BASE(BASE)) dut (
    .clock(clock), .reset_n(reset_n),
    .proc_addr(proc_addr), .proc_data(proc_data), .proc_wren(proc_wren), .proc_hold(proc_hold),
    .proc_q(proc_q), .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  logic [31:0] ram [256];
  always @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < 256; i++) ram[i] <= '0;
      ram_q <= '0;
    end else begin
      if (ram_wren) ram[ram_addr[7:0]] <= ram_data;
      ram_q <= ram[ram_addr[7:0]];
    end
  end

  int          tests_run = 0, tests_failed = 0;
  logic [31:0] q [$];
  logic [31:0] drops_m = '0;
  logic [31:0] ram_m [256];
  logic [31:0] exp_q, exp_data;
  logic        exp_wren, obs_wren, exp_valid;

  // Drives one cycle, advances the reference model across the edge, and returns #1 after it.
  task automatic cycle(input logic [31:0] a, input logic [31:0] d, input logic w, input logic h, input logic r);
    logic [31:0] off;
    logic is_m, ev, popm, acc, drop;
    proc_addr = a; proc_data = d; proc_wren = w; proc_hold = h; out_ready = r;
    #1;
    obs_wren = ram_wren;
    is_m = (a >= BASE);
    off  = a - BASE;
    drop = 1'b0;
    if (!is_m)         exp_q = ram_m[a[7:0]];
    else if (off == 1) exp_q = {24'd0, 4'(q.size()), 2'b00, q.size() == DEPTH, q.size() == 0};
    else if (off == 2) exp_q = drops_m;
    else               exp_q = '0;
    exp_wren = w && !is_m;
    if (exp_wren) ram_m[a[7:0]] = d;
    ev   = w && !h && is_m;
    popm = r && (q.size() > 0);
    if (ev && off == 3 && d[0]) q.delete();
    else begin
      acc = (q.size() < DEPTH) || popm;
      if (popm) void'(q.pop_front());
      if (ev && off == 0) begin
        if (acc) q.push_back(d);
        else     drop = 1'b1;
      end
    end
    if (ev && off == 3 && d[1])           drops_m = '0;
    else if (drop && drops_m != 32'hFFFF_FFFF) drops_m = drops_m + 1;
    exp_valid = (q.size() != 0);
    exp_data  = exp_valid ? q[0] : 32'd0;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b want 0", out_valid); end
    tests_run++; if (out_data !== 32'd0) begin tests_failed++; $display("FAIL reset_data got %h want 0", out_data); end
    tests_run++; if (proc_q !== ram_q) begin tests_failed++; $display("FAIL reset_procq got %h want ram_q %h", proc_q, ram_q); end
    reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_plain();
    cycle(32'd10, 32'h55, 1, 0, 0);
    tests_run++; if (obs_wren !== 1'b1) begin tests_failed++; $display("FAIL plain_wren got %b want 1", obs_wren); end
    cycle(32'd10, 32'h0, 0, 0, 0);
    tests_run++; if (obs_wren !== 1'b0) begin tests_failed++; $display("FAIL plain_rd_wren got %b want 0", obs_wren); end
    tests_run++; if (proc_q !== 32'h55) begin tests_failed++; $display("FAIL plain_load got %h want 55", proc_q); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL plain_fifo got %b want 0", out_valid); end
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 4; i++) cycle(BASE, 32'(i), 1, 0, 0);
    cycle(BASE + 1, 0, 0, 0, 0);
    tests_run++; if (proc_q !== 32'h42) begin tests_failed++; $display("FAIL stream_status_full got %h want 42", proc_q); end
    for (int i = 1; i <= 4; i++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== 32'(i)) begin
        tests_failed++; $display("FAIL stream_word%0d got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, i);
      end
      cycle(32'd0, 0, 0, 0, 1);
    end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL stream_drained got %b want 0", out_valid); end
    cycle(BASE + 1, 0, 0, 0, 1);
    tests_run++; if (proc_q !== 32'h01) begin tests_failed++; $display("FAIL stream_status_empty got %h want 01", proc_q); end
  endtask

  task automatic test_overflow();
    logic [31:0] want [4];
    want = '{32'd12, 32'd13, 32'd14, 32'd9};
    for (int i = 11; i <= 14; i++) cycle(BASE, 32'(i), 1, 0, 0);
    cycle(BASE, 32'd9, 1, 0, 0);
    cycle(BASE + 2, 0, 0, 0, 0);
    tests_run++; if (proc_q !== 32'd1) begin tests_failed++; $display("FAIL ovf_drops got %h want 1", proc_q); end
    cycle(BASE + 1, 0, 0, 0, 0);
    tests_run++; if (proc_q !== 32'h42 || out_data !== 32'd11) begin tests_failed++; $display("FAIL ovf_unchanged got st=%h head=%h want 42/11", proc_q, out_data); end
    cycle(BASE, 32'd9, 1, 0, 1);
    cycle(BASE + 2, 0, 0, 0, 0);
    tests_run++; if (proc_q !== 32'd1) begin tests_failed++; $display("FAIL ovf_pop_push_drops got %h want 1", proc_q); end
    for (int i = 0; i < 4; i++) begin
      tests_run++; if (out_data !== want[i]) begin tests_failed++; $display("FAIL ovf_drain%0d got %h want %h", i, out_data, want[i]); end
      cycle(32'd0, 0, 0, 0, 1);
    end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL ovf_empty got %b want 0", out_valid); end
  endtask

  task automatic test_stall_dedupe();
    cycle(BASE, 32'd7, 1, 0, 0);
    for (int i = 0; i < 4; i++) cycle(BASE, 32'd7, 1, 1, 0);
    cycle(BASE + 1, 0, 0, 0, 0);
    tests_run++; if (proc_q !== 32'h10 || out_data !== 32'd7) begin tests_failed++; $display("FAIL stall_one_push got st=%h head=%h want 10/7", proc_q, out_data); end
    cycle(BASE + 3, 32'd1, 1, 0, 0);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_flush got %b want 0", out_valid); end
  endtask

  task automatic test_flush_race();
    for (int i = 21; i <= 25; i++) cycle(BASE, 32'(i), 1, 0, 0);
    cycle(32'd0, 0, 0, 0, 1);
    cycle(32'd0, 0, 0, 0, 1);
    cycle(BASE + 3, 32'd3, 1, 0, 1);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL race_valid got %b want 0", out_valid); end
    cycle(BASE + 1, 0, 0, 0, 1);
    tests_run++; if (proc_q !== 32'h01) begin tests_failed++; $display("FAIL race_status got %h want 01", proc_q); end
    cycle(BASE + 2, 0, 0, 0, 1);
    tests_run++; if (proc_q !== 32'd0) begin tests_failed++; $display("FAIL race_drops got %h want 0", proc_q); end
  endtask

  task automatic test_random();
    logic [31:0] a;
    int sel;
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4)      a = 32'($urandom_range(0, 255));
      else if (sel < 9) a = BASE + 32'($urandom_range(0, 5));
      else              a = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
      cycle(a, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, $urandom_range(0, 4) < 2);
      tests_run++; if (obs_wren !== exp_wren) begin tests_failed++; $display("FAIL rnd%0d_wren got %b want %b", n, obs_wren, exp_wren); end
      tests_run++; if (proc_q !== exp_q) begin tests_failed++; $display("FAIL rnd%0d_procq a=%h got %h want %h", n, a, proc_q, exp_q); end
      tests_run++; if (out_valid !== exp_valid || out_data !== exp_data) begin
        tests_failed++; $display("FAIL rnd%0d_out got v=%b d=%h want v=%b d=%h", n, out_valid, out_data, exp_valid, exp_data);
      end
    end
  endtask

  task automatic test_reset_midstream();
    cycle(BASE + 3, 32'd3, 1, 0, 0);
    for (int i = 31; i <= 35; i++) cycle(BASE, 32'(i), 1, 0, 0);
    cycle(32'd0, 0, 0, 0, 1);
    proc_wren = 1'b0; out_ready = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_async_valid got %b want 0", out_valid); end
    q.delete(); drops_m = '0;
    for (int i = 0; i < 256; i++) ram_m[i] = '0;
    repeat (2) @(posedge clock);
    #1;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_held_valid got %b want 0", out_valid); end
    reset_n = 1'b1;
    cycle(BASE + 1, 0, 0, 0, 1);
    tests_run++; if (proc_q !== 32'h01) begin tests_failed++; $display("FAIL rst_status got %h want 01", proc_q); end
    cycle(BASE + 2, 0, 0, 0, 1);
    tests_run++; if (proc_q !== 32'd0) begin tests_failed++; $display("FAIL rst_drops got %h want 0", proc_q); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram_m[i] = '0;
    test_reset();
    test_plain();
    test_stream();
    test_overflow();
    test_stall_dedupe();
    test_flush_race();
    test_random();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
